muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: start_i  in  1  E-stage holds a HI/LO-writing mult/div op; held with stable operands while stall_o=1.
REQ-004 SHALL have port: op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports: src_a_i  in  32  rs operand; src_b_i  in  32  rt operand.
REQ-006 SHALL have port: flush_i  in  1  exception/ERET flush; cancels any operation.
REQ-007 SHALL have port: stall_ext_i  in  1  downstream pipeline stall; result held while high.
REQ-008 SHALL have port: stall_o  out  1  freeze F/D/E stages.
REQ-009 SHALL have ports: hi_o  out  32, lo_o  out  32  result registers.
REQ-010 SHALL have port: hilo_wen_o  out  1  single-cycle HI/LO write strobe.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-012 IDLE: start_i & op_i[1]=0 -> MUL; start_i & op_i[1]=1 -> DIV; operands latched on that edge.
REQ-013 MUL: register 64-bit product (signed for MULT, unsigned for MULTU); -> DONE next cycle; result in DONE is {hi_o,lo_o} = product; start-to-DONE latency 2 cycles.
REQ-014 DIV: radix-2 restoring division on magnitudes, one quotient bit per cycle, 32 cycles; -> DONE; latency 33 cycles.
REQ-015 Signed DIV: LO = quotient negated when operand signs differ; HI = remainder with sign of src_a_i.
REQ-016 Divisor zero: LO=32'hFFFFFFFF, HI=src_a_i, no sign correction, no exception.
REQ-017 stall_o = start_i & (state!=DONE) | (state==MUL) | (state==DIV).
REQ-018 DONE: hilo_wen_o = ~stall_ext_i; stall_ext_i=1 -> stay in DONE, hi_o/lo_o held, no strobe; stall_ext_i=0 -> IDLE next cycle.
REQ-019 flush_i has priority over all transitions: any state -> IDLE next edge, hilo_wen_o=0 that cycle, partial result discarded.
REQ-020 start_i while not IDLE SHALL be ignored (no re-latch of operands).
REQ-021 Back-to-back ops: new start_i in the cycle after DONE->IDLE SHALL be accepted normally.

Reset
REQ-022 rst SHALL force IDLE immediately, including mid-operation; hi_o=0, lo_o=0, hilo_wen_o=0, stall_o=start_i, iteration counter=0.

Configuration
REQ-023 Macro MULDIV_DIV0_FAST_EN defined: divisor zero in IDLE -> DONE next cycle (latency 1) with REQ-016 values.
REQ-024 Macro undefined: divisor zero runs full 32 iterations (latency 33), same REQ-016 values.

Structure
REQ-025 Package muldiv_pkg SHALL hold op encodings, state enum, DIV_CYCLES=32, counter width.
REQ-026 Sub-module div_core SHALL hold remainder/quotient shift registers and one restoring step per cycle, driven by load/step controls from muldiv_ctrl.

Verification
REQ-027 MULT a=32'hFFFFFFFD b=5 -> DONE at t+2, hi_o=32'hFFFFFFFF, lo_o=32'hFFFFFFF1, one hilo_wen_o pulse.
REQ-028 DIVU a=100 b=7 -> stall_o high cycles t..t+32, DONE at t+33, lo_o=14, hi_o=2.
REQ-029 DIV a=32'hFFFFFFF9 b=2 -> lo_o=32'hFFFFFFFD, hi_o=32'hFFFFFFFF.
REQ-030 DIVU start, flush_i at iteration 10 -> IDLE next edge, no hilo_wen_o, following MULTU 3*4 -> lo_o=12 at t+2.
REQ-031 DIV a=9 b=0 -> lo_o=32'hFFFFFFFF, hi_o=9; DONE at t+1 with MULDIV_DIV0_FAST_EN, t+33 without.
REQ-032 stall_ext_i high 3 cycles in DONE -> state DONE held, outputs stable, exactly one hilo_wen_o pulse after release; rst mid-DIV -> IDLE, outputs zero.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Optional fast divide-by-zero path: MULDIV_DIV0_FAST_EN.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  function automatic logic [31:0] absVal(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes.
// One quotient bit per step; next-step values exposed for the final write.
module div_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quoNext,
  output logic [31:0] remNext
);

  logic [31:0] quoReg;
  logic [31:0] remReg;
  logic [31:0] dvsReg;
  logic [32:0] shifted;
  logic        ge;

  assign shifted = {remReg, quoReg[31]};
  assign ge      = shifted >= {1'b0, dvsReg};
  assign quoNext = {quoReg[30:0], ge};
  // Difference is below the divisor, so 32-bit wrap is exact
  assign remNext = ge ? (shifted[31:0] - dvsReg)
                      : shifted[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quoReg <= '0;
      remReg <= '0;
      dvsReg <= '0;
    end else if (load) begin
      quoReg <= dividend;
      remReg <= '0;
      dvsReg <= divisor;
    end else if (step) begin
      quoReg <= quoNext;
      remReg <= remNext;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller with pipeline stall handshake.
// Define MULDIV_DIV0_FAST_EN to finish divide-by-zero in one cycle.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  input  logic        stall_ext_i,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        hilo_wen_o
);

  state_e state;
  state_e stateN;

  logic [CNT_W-1:0] cnt;
  logic [1:0]  opReg;
  logic [31:0] aReg;
  logic [31:0] bReg;
  logic [31:0] hiReg;
  logic [31:0] loReg;

  logic        accept;
  logic        resWen;
  logic        hiloWen;
  logic [31:0] resHi;
  logic [31:0] resLo;

  logic        isSigned;
  logic        divZero;
  logic        lastStep;
  logic [63:0] extA;
  logic [63:0] extB;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] qFin;
  logic [31:0] rFin;
  logic        divLoad;
  logic        divStep;

  assign isSigned = ~opReg[0];
  assign divZero  = (bReg == '0);
  assign lastStep = (cnt == CNT_W'(DIV_CYCLES - 1));

  // Sign-extend then truncate: one 64-bit multiply serves both signednesses
  assign extA = {{32{isSigned & aReg[31]}}, aReg};
  assign extB = {{32{isSigned & bReg[31]}}, bReg};
  assign prod = extA * extB;

  assign qFin = divZero ? '1
              : (isSigned & (aReg[31] ^ bReg[31])) ? -quo : quo;
  assign rFin = divZero ? aReg
              : (isSigned & aReg[31]) ? -rem : rem;

  assign divLoad = accept & op_i[1];
  assign divStep = (state == DIV) & ~flush_i;

  div_core uDiv (
    .clk      (clk),
    .rst      (rst),
    .load     (divLoad),
    .step     (divStep),
    .dividend (absVal(src_a_i, ~op_i[0])),
    .divisor  (absVal(src_b_i, ~op_i[0])),
    .quoNext  (quo),
    .remNext  (rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateN;
    end
  end

  always_comb begin
    stateN  = state;
    accept  = 1'b0;
    resWen  = 1'b0;
    resHi   = hiReg;
    resLo   = loReg;
    hiloWen = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          accept = 1'b1;
          stateN = op_i[1] ? DIV : MUL;
`ifdef MULDIV_DIV0_FAST_EN
          if (op_i[1] && (src_b_i == '0)) begin
            stateN = DONE;
            resWen = 1'b1;
            resHi  = src_a_i;
            resLo  = '1;
          end
`endif
        end
      end
      MUL: begin
        stateN         = DONE;
        resWen         = 1'b1;
        {resHi, resLo} = prod;
      end
      DIV: begin
        if (lastStep) begin
          stateN = DONE;
          resWen = 1'b1;
          resHi  = rFin;
          resLo  = qFin;
        end
      end
      DONE: begin
        if (!stall_ext_i) begin
          hiloWen = 1'b1;
          stateN  = IDLE;
        end
      end
      default: stateN = IDLE;
    endcase
    // Flush cancels everything, including a pending result write
    if (flush_i) begin
      stateN  = IDLE;
      accept  = 1'b0;
      resWen  = 1'b0;
      hiloWen = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      opReg <= '0;
      aReg  <= '0;
      bReg  <= '0;
      hiReg <= '0;
      loReg <= '0;
    end else begin
      if (accept) begin
        opReg <= op_i;
        aReg  <= src_a_i;
        bReg  <= src_b_i;
        cnt   <= '0;
      end else if (divStep) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (resWen) begin
        hiReg <= resHi;
        loReg <= resLo;
      end
    end
  end

  assign stall_o = (start_i & (state != DONE))
                 | (state == MUL)
                 | (state == DIV);
  assign hi_o       = hiReg;
  assign lo_o       = loReg;
  assign hilo_wen_o = hiloWen;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed plus randomized bench for muldiv_ctrl.
// Expected HI/LO values come from plain 64-bit arithmetic.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_i;
  logic        stall_ext_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        hilo_wen_o;

  int checks   = 0;
  int failures = 0;

  muldiv_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .src_a_i     (src_a_i),
    .src_b_i     (src_b_i),
    .flush_i     (flush_i),
    .stall_ext_i (stall_ext_i),
    .stall_o     (stall_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .hilo_wen_o  (hilo_wen_o)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {hi, lo} the architecture defines for an op
  function automatic logic [63:0] model(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (op)
      2'd0: res = sa * sb;
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else        res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  function automatic int expLat(
    input logic [1:0]  op,
    input logic [31:0] b
  );
    if (!op[1]) return 2;
`ifdef MULDIV_DIV0_FAST_EN
    if (b == 0) return 1;
`else
    if (b == 0) return 33;
`endif
    return 33;
  endfunction

  // Starts at a negedge in IDLE; returns one negedge after the strobe
  task automatic doOp(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input string       tag
  );
    logic [63:0] exp;
    int  cyc;
    int  stl;
    int  lat;
    bit  done;
    exp     = model(op, a, b);
    lat     = expLat(op, b);
    op_i    = op;
    src_a_i = a;
    src_b_i = b;
    start_i = 1'b1;
    #1;
    stl  = stall_o ? 1 : 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        src_a_i = $urandom;
        src_b_i = $urandom;
      end
      if (hilo_wen_o) done = 1'b1;
      else if (stall_o) stl++;
    end
    start_i = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_lat"}, 64'(cyc), 64'(lat));
    check({tag, "_stall"}, 64'(stl), 64'(lat));
    check({tag, "_hilo"}, {hi_o, lo_o}, exp);
    @(negedge clk);
    check({tag, "_onepulse"}, 64'(hilo_wen_o), 64'd0);
    check({tag, "_idle"}, 64'(stall_o), 64'd0);
  endtask

  initial begin
    logic [63:0] exp;
    logic [63:0] held;
    int          cyc;
    int          wens;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst         = 1'b1;
    start_i     = 1'b0;
    flush_i     = 1'b0;
    stall_ext_i = 1'b0;
    op_i        = 2'd0;
    src_a_i     = '0;
    src_b_i     = '0;
    #1;
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_wen", 64'(hilo_wen_o), 64'd0);
    check("rst_stall0", 64'(stall_o), 64'd0);
    start_i = 1'b1;
    #1;
    check("rst_stall1", 64'(stall_o), 64'd1);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    doOp(2'd0, 32'hFFFF_FFFD, 32'd5, "mult");
    check("mult_lit", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
    doOp(2'd3, 32'd100, 32'd7, "divu");
    check("divu_lit", {hi_o, lo_o}, {32'd2, 32'd14});
    doOp(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    check("div_neg_lit", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    doOp(2'd2, 32'd9, 32'd0, "div0");
    check("div0_lit", {hi_o, lo_o}, {32'd9, 32'hFFFF_FFFF});

    // Flush a DIVU ten iterations in
    held    = {hi_o, lo_o};
    op_i    = 2'd3;
    src_a_i = 32'd1000;
    src_b_i = 32'd3;
    start_i = 1'b1;
    repeat (10) @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_idle", 64'(stall_o), 64'd0);
    wens = 0;
    repeat (40) begin
      @(negedge clk);
      wens += int'(hilo_wen_o);
    end
    check("flush_nowen", 64'(wens), 64'd0);
    check("flush_hilo", {hi_o, lo_o}, held);
    doOp(2'd1, 32'd3, 32'd4, "multu");
    check("multu_lit", 64'(lo_o), 64'd12);

    // Hold the result in DONE with a downstream stall
    exp         = model(2'd0, 32'd7, 32'hFFFF_FFFD);
    stall_ext_i = 1'b1;
    op_i        = 2'd0;
    src_a_i     = 32'd7;
    src_b_i     = 32'hFFFF_FFFD;
    start_i     = 1'b1;
    cyc         = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (stall_o && cyc < 100);
    check("hold_lat", 64'(cyc), 64'd2);
    check("hold_hilo", {hi_o, lo_o}, exp);
    check("hold_wen0", 64'(hilo_wen_o), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("hold_wen", 64'(hilo_wen_o), 64'd0);
      check("hold_state", 64'(stall_o), 64'd0);
      check("hold_stable", {hi_o, lo_o}, exp);
    end
    stall_ext_i = 1'b0;
    start_i     = 1'b0;
    #1;
    check("hold_release", 64'(hilo_wen_o), 64'd1);
    @(negedge clk);
    check("hold_onepulse", 64'(hilo_wen_o), 64'd0);

    // Asynchronous reset mid-divide
    op_i    = 2'd2;
    src_a_i = 32'hFFFF_FFCE;
    src_b_i = 32'd7;
    start_i = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_hilo", {hi_o, lo_o}, 64'd0);
    check("rstmid_wen", 64'(hilo_wen_o), 64'd0);
    check("rstmid_stall", 64'(stall_o), 64'd1);
    start_i = 1'b0;
    #1;
    check("rstmid_idle", 64'(stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    doOp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    doOp(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_min");
    doOp(2'd3, 32'hFFFF_FFFF, 32'd0, "divu0");

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if (i % 6 == 5)      rb = 32'd0;
      else if (i % 3 == 0) rb = 32'($urandom_range(1, 20));
      else                 rb = $urandom;
      doOp(rop, ra, rb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
